i2c_target: RTL

//  I2C target (slave) responder for the bus driven by our I2C master. It oversamples SCL/SDA
//  on the system clock and detects START, repeated START and STOP. It matches a fixed 7-bit

---
 rtl/i2c_target.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target responder: synchronises SCL/SDA, detects START/STOP, matches a 7-bit address,
// ACKs, and delivers write bytes or serves read bytes from the local host.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw_dir
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t state, state_n;

    // Synchronisers idle high so that releasing reset on an idle bus produces no edges.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl, sda, scl_rise, scl_fall, start_ev, stop_ev;

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    // SCL must be high on both sides of the SDA edge; a coincident SCL edge makes it data.
    assign start_ev = ~sda & sda_d & scl & scl_d;
    assign stop_ev  = sda & ~sda_d & scl & scl_d;

    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data_n;
    logic       sda_oe_n, rx_valid_n, tx_req_n, busy_n, rw_dir_n;
    logic       reload, reload_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rw_dir   <= 1'b0;
            reload   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
            rw_dir   <= rw_dir_n;
            reload   <= reload_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy;
        rw_dir_n   = rw_dir;
        reload_n   = reload;

        if (stop_ev) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            reload_n = 1'b0;
        end else if (start_ev) begin
            state_n   = ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd7;
            shift_n   = 8'h00;
            reload_n  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda};
                        if (bit_cnt == 3'd0) begin
                            if (shift[6:0] == TARGET_ADDR) begin
                                rw_dir_n = sda;
                                busy_n   = 1'b1;
                                state_n  = ADDR_ACK;
                            end else begin
                                busy_n  = 1'b0;
                                state_n = WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                // ACK slots: sda_oe is still low on entry, so it doubles as the phase flag.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = 3'd7;
                            if (rw_dir) begin
                                tx_req_n = 1'b1;
                                shift_n  = {tx_data[6:0], 1'b0};
                                sda_oe_n = ~tx_data[7];
                                state_n  = RD_DATA;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda};
                        if (bit_cnt == 3'd0) begin
                            rx_data_n  = {shift[6:0], sda};
                            rx_valid_n = 1'b1;
                            state_n    = WR_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd7;
                            state_n   = WR_DATA;
                        end
                    end
                end
                // shift holds the bits still to be sent; the current bit is already on sda_oe.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (reload) begin
                            reload_n  = 1'b0;
                            tx_req_n  = 1'b1;
                            shift_n   = {tx_data[6:0], 1'b0};
                            sda_oe_n  = ~tx_data[7];
                            bit_cnt_n = 3'd7;
                        end else if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                            state_n  = RD_ACK;
                        end else begin
                            sda_oe_n  = ~shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt - 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            reload_n = 1'b1;
                            state_n  = RD_DATA;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
